// File: rtl/ila_dump.sv
// ila_dump -- readout engine for the ila_core capture buffer.
//
// On a start pulse the engine snapshots the sample count. It then walks the
// capture buffer through ila_core's index/value_select read port. Every
// DATA_W slice of every sample is streamed, in order, on a valid/ready word
// stream. An optional header word carrying the sample count comes first.
//
// Ports:
//   clk_i, arst_n_i       clock, asynchronous active-low reset
//   cke_i                 clock enable; low freezes all state and outputs
//   start_i, abort_i      one-cycle pulses: begin / cancel a dump
//   header_en_i           emit a header word (sample count) before the data
//   samples_i             sample count from ila_core, snapshotted at start
//   index_o, value_select_o  read address and slice select to ila_core
//   value_i               slice read back from ila_core, READ_LAT cycles later
//   m_valid_o, m_data_o, m_last_o, m_ready_i  output word stream
//   busy_o                high while a dump is in progress
//   done_o                one-cycle pulse after the final handshake of a dump
module ila_dump #(
    parameter int DATA_W   = 32,
    parameter int BUFFER_W = 10,
    parameter int SIGNAL_W = 64,
    parameter int SEL_W    = 1,
    parameter int READ_LAT = 2
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cke_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic                header_en_i,
    input  logic [BUFFER_W-1:0] samples_i,
    output logic [BUFFER_W-1:0] index_o,
    output logic [SEL_W-1:0]    value_select_o,
    input  logic [DATA_W-1:0]   value_i,
    output logic                m_valid_o,
    output logic [DATA_W-1:0]   m_data_o,
    output logic                m_last_o,
    input  logic                m_ready_i,
    output logic                busy_o,
    output logic                done_o
);

    localparam int N_PARTS = (SIGNAL_W + DATA_W - 1) / DATA_W;
    localparam int LAT_W   = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [SEL_W-1:0] PART_MAX = SEL_W'(N_PARTS - 1);
    localparam logic [LAT_W-1:0] LAT_MAX  = LAT_W'(READ_LAT - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HDR  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_PUSH = 3'd4;

    logic [2:0]          state_q,   state_d;
    logic [BUFFER_W-1:0] cnt_q,     cnt_d;
    logic [BUFFER_W-1:0] idx_q,     idx_d;
    logic [SEL_W-1:0]    part_q,    part_d;
    logic [LAT_W-1:0]    lat_q,     lat_d;
    logic [BUFFER_W-1:0] index_q,   index_d;
    logic [SEL_W-1:0]    sel_q,     sel_d;
    logic                m_valid_q, m_valid_d;
    logic [DATA_W-1:0]   m_data_q,  m_data_d;
    logic                m_last_q,  m_last_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;

    logic handshake;
    logic last_word;

    assign handshake = m_valid_q & m_ready_i;
    // Only evaluated while a sample is being read, where cnt_q is non-zero.
    assign last_word = (idx_q == cnt_q - BUFFER_W'(1)) && (part_q == PART_MAX);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        part_d    = part_q;
        lat_d     = lat_q;
        index_d   = index_q;
        sel_d     = sel_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_last_d  = m_last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (abort_i && busy_q) begin
            // Abort wins over a handshake in the same cycle; no done pulse.
            state_d   = S_IDLE;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        cnt_d  = samples_i;
                        idx_d  = '0;
                        part_d = '0;
                        if (header_en_i) begin
                            state_d   = S_HDR;
                            busy_d    = 1'b1;
                            m_valid_d = 1'b1;
                            m_data_d  = DATA_W'(samples_i);
                            m_last_d  = (samples_i == '0);
                        end else if (samples_i == '0) begin
                            // Empty dump with nothing to send: finish at once.
                            done_d = 1'b1;
                        end else begin
                            state_d = S_ADDR;
                            busy_d  = 1'b1;
                        end
                    end
                end
                S_HDR: begin
                    if (handshake) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        if (cnt_q == '0) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_ADDR;
                        end
                    end
                end
                S_ADDR: begin
                    index_d = idx_q;
                    sel_d   = part_q;
                    lat_d   = '0;
                    state_d = S_WAIT;
                end
                S_WAIT: begin
                    // The address became visible on entry to WAIT; value_i is
                    // sampled on the READ_LAT-th edge after that.
                    if (lat_q == LAT_MAX) begin
                        m_data_d  = value_i;
                        m_valid_d = 1'b1;
                        m_last_d  = last_word;
                        state_d   = S_PUSH;
                    end else begin
                        lat_d = lat_q + LAT_W'(1);
                    end
                end
                S_PUSH: begin
                    if (handshake) begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        if (m_last_q) begin
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = S_IDLE;
                        end else begin
                            if (part_q == PART_MAX) begin
                                part_d = '0;
                                idx_d  = idx_q + BUFFER_W'(1);
                            end else begin
                                part_d = part_q + SEL_W'(1);
                            end
                            state_d = S_ADDR;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            part_q    <= '0;
            lat_q     <= '0;
            index_q   <= '0;
            sel_q     <= '0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (cke_i) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            part_q    <= part_d;
            lat_q     <= lat_d;
            index_q   <= index_d;
            sel_q     <= sel_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign index_o        = index_q;
    assign value_select_o = sel_q;
    assign m_valid_o      = m_valid_q;
    assign m_data_o       = m_data_q;
    assign m_last_o       = m_last_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;

endmodule

// File: tb/tb_ila_dump.sv
// Testbench for ila_dump: models the ila_core capture buffer as a registered
// read RAM and keeps a scoreboard queue of expected stream words.
module tb_ila_dump;

    localparam int DATA_W   = 32;
    localparam int BUFFER_W = 10;
    localparam int SIGNAL_W = 64;
    localparam int SEL_W    = 1;
    localparam int READ_LAT = 2;

    logic                clk_i = 1'b0;
    logic                arst_n_i;
    logic                cke_i;
    logic                start_i;
    logic                abort_i;
    logic                header_en_i;
    logic [BUFFER_W-1:0] samples_i;
    logic [BUFFER_W-1:0] index_o;
    logic [SEL_W-1:0]    value_select_o;
    logic [DATA_W-1:0]   value_i;
    logic                m_valid_o;
    logic [DATA_W-1:0]   m_data_o;
    logic                m_last_o;
    logic                m_ready_i;
    logic                busy_o;
    logic                done_o;

    int errors = 0;
    int checks = 0;

    logic [63:0] mem [0:1023];
    logic [31:0] exp_q [$];

    always #5 clk_i = ~clk_i;

    // Capture buffer read port: one register stage, so the slice selected by
    // index_o/value_select_o is on value_i before the second edge.
    always @(posedge clk_i) begin
        value_i <= value_select_o[0] ? mem[index_o][63:32] : mem[index_o][31:0];
    end

    ila_dump #(
        .DATA_W  (DATA_W),
        .BUFFER_W(BUFFER_W),
        .SIGNAL_W(SIGNAL_W),
        .SEL_W   (SEL_W),
        .READ_LAT(READ_LAT)
    ) dut (
        .clk_i         (clk_i),
        .arst_n_i      (arst_n_i),
        .cke_i         (cke_i),
        .start_i       (start_i),
        .abort_i       (abort_i),
        .header_en_i   (header_en_i),
        .samples_i     (samples_i),
        .index_o       (index_o),
        .value_select_o(value_select_o),
        .value_i       (value_i),
        .m_valid_o     (m_valid_o),
        .m_data_o      (m_data_o),
        .m_last_o      (m_last_o),
        .m_ready_i     (m_ready_i),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    // Expected words of a complete dump of n samples.
    task automatic push_dump(input int n, input bit hdr);
        if (hdr) exp_q.push_back(32'(n));
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mem[i][31:0]);
            exp_q.push_back(mem[i][63:32]);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the start edge.
    task automatic do_start(input int n, input bit hdr);
        start_i     = 1'b1;
        samples_i   = BUFFER_W'(n);
        header_en_i = hdr;
        m_ready_i   = 1'b0;
        @(posedge clk_i); #1;
        start_i = 1'b0;
    endtask

    // Stream consumer: drives m_ready_i, pops the scoreboard on each
    // handshake and checks data, last flag and stall stability. Returns on
    // done_o, or right after stop_after handshakes when stop_after > 0.
    task automatic consume(input int ready_pct, input int stop_after,
                           output int n_hs, output int min_gap,
                           output int max_gap, output bit done_seen);
        int          last_hs;
        bit          prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        logic [31:0] exp_w;
        bit          exp_last;
        last_hs    = -1;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_last  = 1'b0;
        n_hs       = 0;
        min_gap    = 1000000;
        max_gap    = 0;
        done_seen  = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk_i); #1;
            if (stop_after > 0 && n_hs == stop_after) begin
                m_ready_i = 1'b0;
                return;
            end
            if (done_o) begin
                done_seen = 1'b1;
                m_ready_i = 1'b0;
                return;
            end
            if (prev_stall) begin
                checks++;
                if (m_valid_o !== 1'b1 || m_data_o !== prev_data || m_last_o !== prev_last) begin
                    errors++;
                    $display("FAIL stall_stable: got valid=%0b data=%h last=%0b, expected valid=1 data=%h last=%0b",
                             m_valid_o, m_data_o, m_last_o, prev_data, prev_last);
                end
            end
            m_ready_i  = ($urandom_range(99) < ready_pct);
            prev_stall = m_valid_o && !m_ready_i;
            prev_data  = m_data_o;
            prev_last  = m_last_o;
            if (m_valid_o && m_ready_i) begin
                if (last_hs >= 0) begin
                    if (cyc - last_hs < min_gap) min_gap = cyc - last_hs;
                    if (cyc - last_hs > max_gap) max_gap = cyc - last_hs;
                end
                last_hs = cyc;
                n_hs++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_word: got data=%h, expected no further word", m_data_o);
                end else begin
                    exp_w    = exp_q.pop_front();
                    exp_last = (exp_q.size() == 0);
                    $display("word %0d: data=%h last=%0b (expected %h last=%0b)",
                             n_hs, m_data_o, m_last_o, exp_w, exp_last);
                    if (m_data_o !== exp_w || m_last_o !== exp_last) begin
                        errors++;
                        $display("FAIL word_%0d: got data=%h last=%0b, expected data=%h last=%0b",
                                 n_hs, m_data_o, m_last_o, exp_w, exp_last);
                    end
                end
            end
        end
        m_ready_i = 1'b0;
        checks++;
        errors++;
        $display("FAIL consume_timeout: got no done_o within budget, expected done_o");
    endtask

    task automatic test_reset();
        arst_n_i    = 1'b0;
        cke_i       = 1'b1;
        start_i     = 1'b0;
        abort_i     = 1'b0;
        header_en_i = 1'b0;
        samples_i   = '0;
        m_ready_i   = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if ({m_valid_o, m_last_o, busy_o, done_o} !== 4'b0000 || m_data_o !== '0 ||
            index_o !== '0 || value_select_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b last=%0b busy=%0b done=%0b data=%h idx=%0d sel=%0d, expected all 0",
                     m_valid_o, m_last_o, busy_o, done_o, m_data_o, index_o, value_select_o);
        end
        arst_n_i = 1'b1;
        @(posedge clk_i); #1;
        $display("reset: checked outputs");
    endtask

    task automatic test_basic();
        int n, mn, mx;
        bit dn;
        push_dump(3, 1'b1);
        do_start(3, 1'b1);
        checks++;
        if (busy_o !== 1'b1 || m_valid_o !== 1'b1 || m_data_o !== 32'd3 || m_last_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_header: got busy=%0b valid=%0b data=%h last=%0b, expected 1 1 00000003 0",
                     busy_o, m_valid_o, m_data_o, m_last_o);
        end
        consume(100, 0, n, mn, mx, dn);
        checks++;
        if (n !== 7 || !dn || exp_q.size() != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_count: got words=%0d done=%0b left=%0d busy=%0b, expected 7 1 0 0",
                     n, dn, exp_q.size(), busy_o);
        end
        checks++;
        if (mn != READ_LAT + 2 || mx != READ_LAT + 2) begin
            errors++;
            $display("FAIL basic_throughput: got gap min=%0d max=%0d, expected %0d", mn, mx, READ_LAT + 2);
        end
        @(posedge clk_i); #1;
        checks++;
        if (done_o !== 1'b0 || m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: got done=%0b valid=%0b, expected 0 0", done_o, m_valid_o);
        end
        exp_q.delete();
    endtask

    task automatic test_zero_header();
        int n, mn, mx;
        bit dn;
        push_dump(0, 1'b1);
        do_start(0, 1'b1);
        checks++;
        if (m_valid_o !== 1'b1 || m_last_o !== 1'b1 || m_data_o !== 32'd0) begin
            errors++;
            $display("FAIL zero_hdr_word: got valid=%0b last=%0b data=%h, expected 1 1 00000000",
                     m_valid_o, m_last_o, m_data_o);
        end
        consume(100, 0, n, mn, mx, dn);
        checks++;
        if (n !== 1 || !dn) begin
            errors++;
            $display("FAIL zero_hdr_count: got words=%0d done=%0b, expected 1 1", n, dn);
        end
        exp_q.delete();
    endtask

    task automatic test_zero_noheader();
        do_start(0, 1'b0);
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_nohdr_done: got done=%0b busy=%0b valid=%0b, expected 1 0 0",
                     done_o, busy_o, m_valid_o);
        end
        @(posedge clk_i); #1;
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || m_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL zero_nohdr_after: got done=%0b busy=%0b valid=%0b, expected 0 0 0",
                     done_o, busy_o, m_valid_o);
        end
    endtask

    task automatic test_stalls();
        int n, mn, mx;
        bit dn;
        push_dump(5, 1'b0);
        do_start(5, 1'b0);
        consume(40, 0, n, mn, mx, dn);
        checks++;
        if (n !== 10 || !dn || exp_q.size() != 0) begin
            errors++;
            $display("FAIL stalls_count: got words=%0d done=%0b left=%0d, expected 10 1 0", n, dn, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_cke();
        int n, mn, mx;
        bit dn;
        push_dump(2, 1'b1);
        do_start(2, 1'b1);
        cke_i     = 1'b0;
        m_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (m_valid_o !== 1'b1 || m_data_o !== 32'd2 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL cke_freeze: got valid=%0b data=%h busy=%0b, expected 1 00000002 1",
                     m_valid_o, m_data_o, busy_o);
        end
        m_ready_i = 1'b0;
        cke_i     = 1'b1;
        consume(70, 0, n, mn, mx, dn);
        checks++;
        if (n !== 5 || !dn) begin
            errors++;
            $display("FAIL cke_count: got words=%0d done=%0b, expected 5 1", n, dn);
        end
        exp_q.delete();
    endtask

    task automatic test_abort();
        int  n, mn, mx;
        bit  dn;
        bit  bad;
        push_dump(5, 1'b1);
        do_start(5, 1'b1);
        consume(100, 4, n, mn, mx, dn);
        abort_i = 1'b1;
        @(posedge clk_i); #1;
        abort_i = 1'b0;
        checks++;
        if (m_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 || n !== 4) begin
            errors++;
            $display("FAIL abort_stop: got valid=%0b busy=%0b done=%0b words=%0d, expected 0 0 0 4",
                     m_valid_o, busy_o, done_o, n);
        end
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i); #1;
            if (done_o || m_valid_o || busy_o) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL abort_quiet: got activity after abort, expected none");
        end
        exp_q.delete();
        // Fresh dump, with abort asserted alongside start in IDLE.
        push_dump(5, 1'b1);
        abort_i = 1'b1;
        do_start(5, 1'b1);
        abort_i = 1'b0;
        checks++;
        if (busy_o !== 1'b1 || m_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_restart: got busy=%0b valid=%0b, expected 1 1", busy_o, m_valid_o);
        end
        consume(100, 0, n, mn, mx, dn);
        checks++;
        if (n !== 11 || !dn) begin
            errors++;
            $display("FAIL abort_redump: got words=%0d done=%0b, expected 11 1", n, dn);
        end
        exp_q.delete();
    endtask

    task automatic test_midstart();
        int n1, n2, mn, mx;
        bit dn;
        push_dump(4, 1'b1);
        do_start(4, 1'b1);
        consume(70, 3, n1, mn, mx, dn);
        start_i     = 1'b1;
        samples_i   = BUFFER_W'(9);
        header_en_i = 1'b0;
        @(posedge clk_i); #1;
        start_i   = 1'b0;
        samples_i = BUFFER_W'(2);
        consume(70, 0, n2, mn, mx, dn);
        checks++;
        if (n1 + n2 !== 9 || !dn || exp_q.size() != 0) begin
            errors++;
            $display("FAIL midstart_count: got words=%0d done=%0b left=%0d, expected 9 1 0",
                     n1 + n2, dn, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
        test_reset();
        test_basic();
        test_zero_header();
        test_zero_noheader();
        test_stalls();
        test_cke();
        test_abort();
        test_midstart();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
